// File: rtl/instr_issue_queue_pkg.sv
// Shared definitions for the instruction issue queue: FSM encoding,
// RV32 opcode constants and an I-type encoder for host logic and benches.
package instr_issue_queue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } issue_state_e;

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [2:0] F3_ADDI = 3'b000;

  function automatic logic [31:0] encode_itype(
    input logic [6:0]  opcode,
    input logic [2:0]  funct3,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [11:0] imm12
  );
    return {imm12, rs1, funct3, rd, opcode};
  endfunction

endpackage

// File: rtl/issue_fifo_mem.sv
// Entry storage for the issue queue: registered write port and a
// combinational read of the head entry.
module issue_fifo_mem
  import instr_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REPEAT_W = 8
) (
  input  logic                         clk_i,
  input  logic                         we_i,
  input  logic [$clog2(DEPTH)-1:0]     waddr_i,
  input  logic [XLEN+REPEAT_W-1:0]     wdata_i,
  input  logic [$clog2(DEPTH)-1:0]     raddr_i,
  output logic [XLEN+REPEAT_W-1:0]     rdata_o
);

  logic [XLEN+REPEAT_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_issue_queue.sv
// Instruction issue queue: buffers host-written instructions and presents
// each one to the CPU a programmable number of times with idle gaps.
module instr_issue_queue
  import instr_issue_queue_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned REPEAT_W = 8,
  parameter int unsigned GAP_W    = 4
) (
  input  logic                         cpu_clk,
  input  logic                         cpu_rst_n,
  input  logic                         wr_valid,
  input  logic [XLEN-1:0]              wr_instr,
  input  logic [REPEAT_W-1:0]          wr_repeat,
  output logic                         wr_ready,
  input  logic [GAP_W-1:0]             gap_cycles,
  input  logic                         flush,
  input  logic                         cpu_take,
  output logic [XLEN-1:0]              cpu_instruction,
  output logic                         cpu_instruction_RDY_BSY,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [15:0]                  issued_total
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = XLEN + REPEAT_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  issue_state_e         state_q;
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic [CW-1:0]        count_d;
  logic [REPEAT_W-1:0]  done_q;
  logic [GAP_W-1:0]     gap_q;
  logic [15:0]          issued_q;

  logic [EW-1:0]        head;
  logic [XLEN-1:0]      head_instr;
  logic [REPEAT_W-1:0]  head_rep;
  logic [REPEAT_W-1:0]  wr_rep_norm;
  logic                 wr_fire;
  logic                 issue_fire;
  logic                 last_rep;
  logic                 pop;

  issue_fifo_mem #(
    .DEPTH    (DEPTH),
    .XLEN     (XLEN),
    .REPEAT_W (REPEAT_W)
  ) u_mem (
    .clk_i   (cpu_clk),
    .we_i    (wr_fire),
    .waddr_i (wr_ptr_q),
    .wdata_i ({wr_rep_norm, wr_instr}),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign head_instr = head[XLEN-1:0];
  assign head_rep   = head[EW-1:XLEN];

  // Repeats are tracked as issues already done against the stored count,
  // so a pop can move straight to the next head without a preload cycle.
  always_comb begin
    wr_rep_norm = (wr_repeat == '0) ? REPEAT_W'(1) : wr_repeat;
    wr_fire     = wr_valid && wr_ready && !flush;
    issue_fire  = (state_q == ST_ISSUE) && cpu_take;
    last_rep    = (done_q == (head_rep - REPEAT_W'(1)));
    pop         = issue_fire && last_rep;
    count_d     = count_q;
    if (wr_fire && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !wr_fire) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= '0;
      gap_q    <= '0;
      issued_q <= '0;
    end else if (flush) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= '0;
      gap_q    <= '0;
      issued_q <= '0;
    end else begin
      count_q <= count_d;
      if (wr_fire) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (count_q != '0) begin
            state_q <= ST_ISSUE;
            done_q  <= '0;
          end
        end
        ST_ISSUE: begin
          if (issue_fire) begin
            issued_q <= issued_q + 16'd1;
            done_q   <= last_rep ? '0 : done_q + REPEAT_W'(1);
            if (gap_cycles != '0) begin
              state_q <= ST_GAP;
              gap_q   <= gap_cycles;
            end else if (count_d == '0) begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_W'(1)) begin
            state_q <= (count_q != '0) ? ST_ISSUE : ST_IDLE;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_ready                = (count_q != FULL);
  assign cpu_instruction_RDY_BSY = (state_q == ST_ISSUE);
  assign cpu_instruction         = cpu_instruction_RDY_BSY ? head_instr : '0;
  assign count                   = count_q;
  assign issued_total            = issued_q;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed bench for instr_issue_queue with a queue-based scoreboard of
// expected instructions and remaining repeat counts.
module tb_instr_issue_queue;
  import instr_issue_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam logic [31:0] ADDI_X1_X2_5 = 32'h00510093;

  logic        cpu_clk;
  logic        cpu_rst_n;
  logic        wr_valid;
  logic [31:0] wr_instr;
  logic [7:0]  wr_repeat;
  logic        wr_ready;
  logic [3:0]  gap_cycles;
  logic        flush;
  logic        cpu_take;
  logic [31:0] cpu_instruction;
  logic        rdy;
  logic [3:0]  count;
  logic [15:0] issued_total;

  instr_issue_queue #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .REPEAT_W (8),
    .GAP_W    (4)
  ) dut (
    .cpu_clk                 (cpu_clk),
    .cpu_rst_n               (cpu_rst_n),
    .wr_valid                (wr_valid),
    .wr_instr                (wr_instr),
    .wr_repeat               (wr_repeat),
    .wr_ready                (wr_ready),
    .gap_cycles              (gap_cycles),
    .flush                   (flush),
    .cpu_take                (cpu_take),
    .cpu_instruction         (cpu_instruction),
    .cpu_instruction_RDY_BSY (rdy),
    .count                   (count),
    .issued_total            (issued_total)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic [31:0] instr;
    int          rep;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   exp_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int i);
    return encode_itype(OP_IMM, F3_ADDI, 5'(i + 1), 5'd2, 12'(i));
  endfunction

  // Applies the current inputs for one clock, updating the scoreboard with
  // what should be written/issued, then checks occupancy and totals.
  task automatic tick();
    logic fi;
    logic fw;
    exp_t e;
    fi = rdy && cpu_take && !flush;
    fw = wr_valid && (sb.size() < DEPTH) && !flush;
    if (flush) begin
      sb.delete();
      exp_total = 0;
    end else begin
      if (fi) begin
        if (sb.size() == 0) begin
          chk("issue_unexpected", 32'(rdy), 32'd0);
        end else begin
          chk("issue_instr", cpu_instruction, sb[0].instr);
          e = sb[0];
          e.rep--;
          exp_total++;
          if (e.rep == 0) sb.pop_front();
          else sb[0] = e;
        end
      end
      if (fw) begin
        e.instr = wr_instr;
        e.rep   = (wr_repeat == 8'd0) ? 1 : int'(wr_repeat);
        sb.push_back(e);
      end
    end
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    chk("count", 32'(count), 32'(sb.size()));
    chk("wr_ready", 32'(wr_ready), 32'(sb.size() != DEPTH));
    chk("issued_total", 32'(issued_total), 32'(16'(exp_total)));
  endtask

  initial begin
    int n_iss;
    int viol;
    int iters;
    logic prev;

    cpu_rst_n  = 1'b0;
    wr_valid   = 1'b0;
    wr_instr   = '0;
    wr_repeat  = '0;
    gap_cycles = '0;
    flush      = 1'b0;
    cpu_take   = 1'b0;

    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_instr", cpu_instruction, 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_issued", 32'(issued_total), 32'd0);
    chk("pkg_encode", encode_itype(OP_IMM, F3_ADDI, 5'd1, 5'd2, 12'd5), ADDI_X1_X2_5);

    @(negedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst_n = 1'b1;

    // Single ADDI, repeat 1, no gap
    wr_valid = 1'b1; wr_instr = ADDI_X1_X2_5; wr_repeat = 8'd1; cpu_take = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk("t1_latency_low", 32'(rdy), 32'd0);
    tick();
    chk("t1_rdy", 32'(rdy), 32'd1);
    chk("t1_instr", cpu_instruction, ADDI_X1_X2_5);
    tick();
    chk("t1_idle", 32'(rdy), 32'd0);
    chk("t1_issued", 32'(issued_total), 32'd1);

    // repeat of 0 behaves as a single issue
    wr_valid = 1'b1; wr_instr = ent(30); wr_repeat = 8'd0;
    tick();
    wr_valid = 1'b0;
    tick();
    chk("rep0_rdy", 32'(rdy), 32'd1);
    tick();
    chk("rep0_idle", 32'(rdy), 32'd0);
    chk("rep0_issued", 32'(issued_total), 32'd2);

    // Repeat 11 with a one-cycle gap
    flush = 1'b1;
    tick();
    flush = 1'b0;
    gap_cycles = 4'd1;
    wr_valid = 1'b1; wr_instr = ADDI_X1_X2_5; wr_repeat = 8'd11;
    tick();
    wr_valid = 1'b0;
    n_iss = 0; viol = 0; iters = 0; prev = 1'b0;
    while (iters < 60 && sb.size() != 0) begin
      if (rdy) begin
        n_iss++;
        if (prev) viol++;
      end
      prev = rdy;
      iters++;
      tick();
    end
    chk("t2_issues", 32'(n_iss), 32'd11);
    chk("t2_no_back_to_back", 32'(viol), 32'd0);
    chk("t2_cycles", 32'(iters), 32'd22);
    chk("t2_issued", 32'(issued_total), 32'd11);
    tick();
    tick();
    chk("t2_idle", 32'(rdy), 32'd0);
    chk("t2_count", 32'(count), 32'd0);
    gap_cycles = 4'd0;

    // Fill the queue with cpu_take low; ninth write is refused
    cpu_take = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1; wr_instr = ent(i); wr_repeat = 8'd1;
      tick();
    end
    wr_valid = 1'b0;
    chk("t3_count", 32'(count), 32'd8);
    chk("t3_wr_ready", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_rdy", 32'(rdy), 32'd1);
      chk("t3_hold_instr", cpu_instruction, ent(0));
      tick();
    end

    // Pop and write on a full queue
    wr_valid = 1'b1; wr_instr = ent(9); cpu_take = 1'b1;
    tick();
    wr_valid = 1'b0; cpu_take = 1'b0;
    chk("t4_count", 32'(count), 32'd7);
    chk("t4_wr_ready", 32'(wr_ready), 32'd1);
    chk("t4_next_head", cpu_instruction, ent(1));

    // Flush in the middle of issuing
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 10; i < 13; i++) begin
      wr_valid = 1'b1; wr_instr = ent(i); wr_repeat = 8'd2;
      tick();
    end
    wr_valid = 1'b0;
    chk("t5_issue", 32'(rdy), 32'd1);
    cpu_take = 1'b1;
    tick();
    chk("t5_one_issue", 32'(issued_total), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0; cpu_take = 1'b0;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_rdy", 32'(rdy), 32'd0);
    chk("t5_issued", 32'(issued_total), 32'd0);
    chk("t5_instr", cpu_instruction, 32'd0);

    // Asynchronous reset during a gap
    gap_cycles = 4'd3;
    wr_valid = 1'b1; wr_instr = ent(20); wr_repeat = 8'd3; cpu_take = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
    chk("t6_rdy", 32'(rdy), 32'd1);
    tick();
    chk("t6_gap", 32'(rdy), 32'd0);
    #2 cpu_rst_n = 1'b0;
    #1;
    sb.delete();
    exp_total = 0;
    chk("t6_async_rdy", 32'(rdy), 32'd0);
    chk("t6_async_instr", cpu_instruction, 32'd0);
    chk("t6_async_count", 32'(count), 32'd0);
    chk("t6_async_wr_ready", 32'(wr_ready), 32'd1);
    chk("t6_async_issued", 32'(issued_total), 32'd0);
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    chk("t6_held_issued", 32'(issued_total), 32'd0);
    chk("t6_held_rdy", 32'(rdy), 32'd0);
    cpu_rst_n = 1'b1;
    cpu_take = 1'b0;
    gap_cycles = 4'd0;
    tick();
    tick();
    chk("t6_discarded", 32'(rdy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
